regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (RegWr/RW/BusW, committed on negedge Clk) between two writeback requesters.
- Requester A is the ALU/main writeback; requester B is the load or multi-cycle unit.
- Each requester has a 1-entry holding buffer with a valid/ready handshake.
- Grants one write per cycle and drives registered outputs that stay stable across the negedge commit.
- Exports a per-register pending-write mask (Busy) for hazard/stall logic.

Parameters:
- DATA_W, 64, write data width (matches BusW).
- ADDR_W, 5, register index width; 2**ADDR_W registers; index all-ones (X31) is the zero register.

Ports:
- Clk  input  1  system clock; all state updates on posedge.
- Reset_L  input  1  asynchronous, active-low reset.
- ReqA_Valid  input  1  requester A offers a write.
- ReqA_Ready  output  1  A's write is accepted at this posedge if Valid is high.
- ReqA_RW  input  ADDR_W  A's destination register.
- ReqA_Data  input  DATA_W  A's write data.
- ReqB_Valid, ReqB_Ready, ReqB_RW, ReqB_Data  as for A, requester B.
- RegWr  output  1  write enable to the register file.
- RW  output  ADDR_W  write address to the register file.
- BusW  output  DATA_W  write data to the register file.
- Busy  output  2**ADDR_W  bit r=1: a write to register r is buffered or on the output stage.
- Idle  output  1  both buffers empty and RegWr=0.

Behaviour:
- Interface: one clock (Clk); reset (Reset_L) is asynchronous and active-low.
- Reset (Reset_L=0, any time, including mid-transfer):
  - Both buffers empty; RegWr=0, RW=0, BusW=0, Busy=0, Idle=1.
  - Round-robin pointer set to "B last", so A is favoured first.
  - Age flag cleared.
  - In-flight buffered writes are discarded.
- Per-requester buffer state: Full, RW, Data, and a load timestamp via a shared age flag (which buffer loaded first).
- Ready (combinational): Ready_x = !Full_x | Grant_x.
  - Grant_x is this cycle's grant, computed only from buffer state.
  - No combinational path from Valid or RW/Data to Ready.
- Accept: at posedge, if Valid_x & Ready_x:
  - RW_x != 31: buffer loads; Full_x=1.
  - RW_x == 31: write is dropped. The handshake completes, but the buffer is not loaded, Busy is unchanged, and RegWr is never raised for it.
- Arbitration, evaluated each cycle over Full flags:
  - One full buffer: grant it.
  - Both full, same RW: grant the older buffer (age flag). If both loaded on the same edge, grant A.
  - Both full, different RW: without the macro, A wins (fixed priority; B may starve). With RR_ARB_EN, grant the one not granted last.
- Output stage: at posedge, if a grant exists:
  - RegWr<=1, RW<=granted RW, BusW<=granted Data.
  - Granted buffer clears, unless reloaded the same edge via Ready.
  - If no grant: RegWr<=0; RW and BusW hold their values.
- Latency: accepted at posedge N, then RegWr=1 during cycle N+1 at the earliest; the register file commits on the negedge inside cycle N+1.
- Throughput: 1 write/cycle total; a requester that is continuously granted sustains 1/cycle.
- Busy[r] = (Full_A & RW_A==r) | (Full_B & RW_B==r) | (RegWr & RW==r). Busy[31] is always 0.
- Age flag updates on each load and each grant so that it always identifies the older of the two full buffers.

Optional Feature:
- Macro RR_ARB_EN.
- Defined: round-robin between A and B on conflicts with different RW. The pointer updates only when both were full and a grant was made.
- Undefined: fixed priority, A over B. The pointer logic is not compiled.
- Both builds keep the same-register age rule.

Test Plan:
- Reset: assert Reset_L=0 asynchronously while A is full (X3) and RegWr=1 -> immediately RegWr=0, RW=0, BusW=0, Busy=0, Idle=1. After release, the X3 write never appears.
- Single write: A Valid, RW=5, Data=0x1234 accepted at edge N -> cycle N+1: RegWr=1, RW=5, BusW=0x1234, Busy[5]=1. Cycle N+2: RegWr=0, Idle=1. Register-file readback of X5=0x1234.
- Simultaneous: A X1=0x11 and B X2=0x22 accepted on the same edge -> RegWr sequence X1 then X2 on consecutive cycles. ReqB_Ready=0 during the first grant cycle.
- Contention, both Valid every cycle to X1/X2: with RR_ARB_EN, RW alternates 1,2,1,2. Without it, RW=1 every cycle and ReqB_Ready stays 0.
- X31: B Valid, RW=31, Data=0xFFFF -> Ready=1 and accepted, RegWr stays 0, Busy all 0, Idle=1.
- Same-register ordering (no macro): B holds X7=0xAA stalled behind A's stream; A then loads X7=0xBB -> X7=0xAA written before X7=0xBB; final X7 readback is 0xBB.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter sharing the register-file write port.
// Define RR_ARB_EN for round-robin on different-register conflicts.
module regfile_write_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic                   Clk,
  input  logic                   Reset_L,
  input  logic                   ReqA_Valid,
  output logic                   ReqA_Ready,
  input  logic [ADDR_W-1:0]      ReqA_RW,
  input  logic [DATA_W-1:0]      ReqA_Data,
  input  logic                   ReqB_Valid,
  output logic                   ReqB_Ready,
  input  logic [ADDR_W-1:0]      ReqB_RW,
  input  logic [DATA_W-1:0]      ReqB_Data,
  output logic                   RegWr,
  output logic [ADDR_W-1:0]      RW,
  output logic [DATA_W-1:0]      BusW,
  output logic [(2**ADDR_W)-1:0] Busy,
  output logic                   Idle
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZREG = '1;

  logic              full_a;
  logic              full_b;
  logic [ADDR_W-1:0] rw_a;
  logic [ADDR_W-1:0] rw_b;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic              b_first;
  logic              grant_a;
  logic              grant_b;
  logic              load_a;
  logic              load_b;
  logic              both;
  logic              same;
  logic              pick_a;

  assign both = full_a & full_b;
  assign same = (rw_a == rw_b);

`ifdef RR_ARB_EN
  logic last_b;

  // Conflict winner is whoever was not served on the last conflict.
  assign pick_a = last_b;

  // Pointer advances only when both buffers competed.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      last_b <= 1'b1;
    end else if (both) begin
      last_b <= grant_b;
    end
  end
`else
  // Fixed priority: A always wins a different-register conflict.
  assign pick_a = 1'b1;
`endif

  // Grant decision from buffer state only, so Ready never sees Valid.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    unique case (1'b1)
      both & same: begin
        grant_a = ~b_first;
        grant_b = b_first;
      end
      both & ~same: begin
        grant_a = pick_a;
        grant_b = ~pick_a;
      end
      full_a & ~full_b: grant_a = 1'b1;
      full_b & ~full_a: grant_b = 1'b1;
      default: begin
        grant_a = 1'b0;
        grant_b = 1'b0;
      end
    endcase
  end

  assign ReqA_Ready = ~full_a | grant_a;
  assign ReqB_Ready = ~full_b | grant_b;

  // Writes to the zero register complete the handshake but never load.
  assign load_a = ReqA_Valid & ReqA_Ready & (ReqA_RW != ZREG);
  assign load_b = ReqB_Valid & ReqB_Ready & (ReqB_RW != ZREG);

  // Holding buffer A: load wins over the clear from its own grant.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      full_a <= 1'b0;
      rw_a   <= '0;
      data_a <= '0;
    end else if (load_a) begin
      full_a <= 1'b1;
      rw_a   <= ReqA_RW;
      data_a <= ReqA_Data;
    end else if (grant_a) begin
      full_a <= 1'b0;
    end
  end

  // Holding buffer B: load wins over the clear from its own grant.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      full_b <= 1'b0;
      rw_b   <= '0;
      data_b <= '0;
    end else if (load_b) begin
      full_b <= 1'b1;
      rw_b   <= ReqB_RW;
      data_b <= ReqB_Data;
    end else if (grant_b) begin
      full_b <= 1'b0;
    end
  end

  // Age flag: set when B stays put while A takes a newer entry;
  // cleared whenever B loads (same-edge loads count A as older).
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      b_first <= 1'b0;
    end else if (load_b) begin
      b_first <= 1'b0;
    end else if (load_a & full_b & ~grant_b) begin
      b_first <= 1'b1;
    end
  end

  // Registered write port, stable through the negedge commit.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      RegWr <= 1'b0;
      RW    <= '0;
      BusW  <= '0;
    end else if (grant_a) begin
      RegWr <= 1'b1;
      RW    <= rw_a;
      BusW  <= data_a;
    end else if (grant_b) begin
      RegWr <= 1'b1;
      RW    <= rw_b;
      BusW  <= data_b;
    end else begin
      RegWr <= 1'b0;
    end
  end

  // Pending-write mask; the zero register is never marked busy.
  always_comb begin
    Busy = '0;
    for (int r = 0; r < NREG - 1; r++) begin
      Busy[r] = (full_a & (rw_a == ADDR_W'(r)))
              | (full_b & (rw_b == ADDR_W'(r)))
              | (RegWr  & (RW   == ADDR_W'(r)));
    end
  end

  assign Idle = ~full_a & ~full_b & ~RegWr;

endmodule
